// File: rtl/piso_serializer.sv
// Parallel-in / serial-out framer: one word in, WIDTH bits out, one per clock.
// Optional even-parity trailer bit is compiled in with PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for a word; load_ready high
    // SHIFT  | presenting data bits, cnt = index of the bit on serial_out
    // PARITY | presenting the even-parity bit (PISO_PARITY_EN builds only)

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             next_bit;
    logic             first_bit;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    // shreg always holds the word aligned so its outgoing end is the bit on serial_out
    always_comb begin
        shreg_next = shreg;
        next_bit   = 1'b0;
        first_bit  = 1'b0;
        if (LSB_FIRST != 0) begin
            shreg_next = shreg >> 1;
            next_bit   = shreg[1];
            first_bit  = data_in[0];
        end else begin
            shreg_next = shreg << 1;
            next_bit   = shreg[WIDTH-2];
            first_bit  = data_in[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b0;
`ifdef PISO_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out   <= 1'b0;
                    serial_valid <= 1'b0;
                    if (load_valid) begin
                        shreg        <= data_in;
                        cnt          <= '0;
                        serial_out   <= first_bit;
                        serial_valid <= 1'b1;
                        state        <= SHIFT;
`ifdef PISO_PARITY_EN
                        parity       <= ^data_in;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
                        state        <= PARITY;
                        serial_out   <= parity;
                        serial_valid <= 1'b1;
`else
                        state        <= IDLE;
                        done         <= 1'b1;
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
`endif
                    end else begin
                        cnt          <= cnt + CW'(1);
                        shreg        <= shreg_next;
                        serial_out   <= next_bit;
                        serial_valid <= 1'b1;
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state        <= IDLE;
                    done         <= 1'b1;
                    serial_out   <= 1'b0;
                    serial_valid <= 1'b0;
                end
`endif
                default: begin
                    state        <= IDLE;
                    serial_out   <= 1'b0;
                    serial_valid <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (state == IDLE);
    assign busy       = ~load_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one LSB-first and one MSB-first instance, scoreboarded
// serial streams, frame timing checks and a SIPO loopback model.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][3:0] data_in;
    logic [1:0]      load_valid;
    logic [1:0]      load_ready;
    logic [1:0]      serial_out;
    logic [1:0]      serial_valid;
    logic [1:0]      busy;
    logic [1:0]      done;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic q0[$];
    logic q1[$];
    logic exp_b;
    logic [3:0] sipo;
    int   bitpos;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .data_in(data_in[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .serial_out(serial_out[0]),
        .serial_valid(serial_valid[0]), .busy(busy[0]), .done(done[0])
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .serial_out(serial_out[1]),
        .serial_valid(serial_valid[1]), .busy(busy[1]), .done(done[1])
    );

    // Scoreboard: every presented bit must match the next expected bit; idle output must be 0.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (serial_valid[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_fail++;
                        $display("FAIL stream%0d: unexpected bit %b, expected no bit", d, serial_out[d]);
                    end else begin
                        if (d == 0) exp_b = q0.pop_front();
                        else        exp_b = q1.pop_front();
                        if (serial_out[d] !== exp_b) begin
                            n_fail++;
                            $display("FAIL stream%0d: got %b expected %b at %0t", d, serial_out[d], exp_b, $time);
                        end
                    end
                end else if (serial_out[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_out%0d: got %b expected 0", d, serial_out[d]);
                end
            end
        end
    end

    // Right-shifting 4-bit SIPO on the LSB-first stream; only data bits shift in.
    always @(posedge clk) begin
        if (reset) begin
            sipo   <= 4'b0;
            bitpos <= 0;
        end else if (serial_valid[0]) begin
            if (bitpos < 4) sipo <= {serial_out[0], sipo[3:1]};
            bitpos <= (bitpos == FRAME - 1) ? 0 : bitpos + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int d, input logic [3:0] w);
        logic b;
        for (int i = 0; i < 4; i++) begin
            b = (d == 0) ? w[i] : w[3-i];
            if (d == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
`ifdef PISO_PARITY_EN
        if (d == 0) q0.push_back(^w);
        else        q1.push_back(^w);
`endif
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (load_ready[d] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (load_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout%0d: load_ready=%b after %0d cycles, expected 1", d, load_ready[d], n);
        end
    endtask

    // Entered in cycle 1 of a frame; leaves at the negedge of the done cycle.
    task automatic check_frame(input int d, input logic [3:0] w);
        int qs;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy[d] !== 1'b1 || load_ready[d] !== 1'b0 || serial_valid[d] !== 1'b1 || done[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_timing%0d c%0d: busy=%b ready=%b valid=%b done=%b, expected 1 0 1 0",
                         d, c, busy[d], load_ready[d], serial_valid[d], done[d]);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (done[d] !== 1'b1 || load_ready[d] !== 1'b1 || busy[d] !== 1'b0 || serial_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle%0d: done=%b ready=%b busy=%b valid=%b, expected 1 1 0 0",
                     d, done[d], load_ready[d], busy[d], serial_valid[d]);
        end
        qs = (d == 0) ? q0.size() : q1.size();
        n_checks++;
        if (qs != 0) begin
            n_fail++;
            $display("FAIL frame_len%0d: %0d expected bits not seen, expected 0", d, qs);
        end
        if (d == 0) begin
            n_checks++;
            if (sipo !== w) begin
                n_fail++;
                $display("FAIL loopback: sipo=%b expected %b", sipo, w);
            end
        end
    endtask

    task automatic run_frame(input int d, input logic [3:0] w);
        wait_ready(d);
        push_word(d, w);
        data_in[d]    = w;
        load_valid[d] = 1'b1;
        step();
        load_valid[d] = 1'b0;
        data_in[d]    = ~w;
        check_frame(d, w);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 2'b11;
        data_in[0] = 4'b1011;
        data_in[1] = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (load_ready[d] !== 1'b1 || busy[d] !== 1'b0 || serial_valid[d] !== 1'b0 ||
                    serial_out[d] !== 1'b0 || done[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state%0d: ready=%b busy=%b valid=%b out=%b done=%b, expected 1 0 0 0 0",
                             d, load_ready[d], busy[d], serial_valid[d], serial_out[d], done[d]);
                end
            end
        end
        step();
        reset      = 1'b0;
        load_valid = 2'b00;
        step();
    endtask

    task automatic test_lsb_first();
        run_frame(0, 4'b1011);
    endtask

    task automatic test_msb_first();
        run_frame(1, 4'b1011);
    endtask

    task automatic test_busy_ignore();
        wait_ready(0);
        push_word(0, 4'b1011);
        push_word(0, 4'b0110);
        data_in[0]    = 4'b1011;
        load_valid[0] = 1'b1;
        step();
        data_in[0] = 4'b0110;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (load_ready[0] !== 1'b0 || busy[0] !== 1'b1 || serial_valid[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ignore c%0d: ready=%b busy=%b valid=%b, expected 0 1 1",
                         c, load_ready[0], busy[0], serial_valid[0]);
            end
            step();
        end
        @(negedge clk);
        n_checks++;
        if (done[0] !== 1'b1 || load_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: done=%b ready=%b, expected 1 1", done[0], load_ready[0]);
        end
        step();
        load_valid[0] = 1'b0;
        data_in[0]    = 4'b0000;
        check_frame(0, 4'b0110);
    endtask

    task automatic test_abort();
        wait_ready(0);
        push_word(0, 4'b1011);
        data_in[0]    = 4'b1011;
        load_valid[0] = 1'b1;
        step();
        load_valid[0] = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        q0.delete();
        @(negedge clk);
        n_checks++;
        if (serial_valid[0] !== 1'b0 || busy[0] !== 1'b0 || load_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: valid=%b busy=%b ready=%b done=%b, expected 0 0 1 0",
                     serial_valid[0], busy[0], load_ready[0], done[0]);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            n_checks++;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet c%0d: done=%b busy=%b, expected 0 0", c, done[0], busy[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        run_frame(0, 4'b0000);
        run_frame(0, 4'b1111);
        for (int n = 0; n < 8; n++) begin
            w = 4'($urandom_range(0, 15));
            run_frame(0, w);
        end
        for (int n = 0; n < 3; n++) begin
            w = 4'($urandom_range(0, 15));
            run_frame(1, w);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 2'b00;
        data_in    = '0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        repeat (4) step();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d bits outstanding, expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
